memory_bram_arbiter: RTL and testbench

MEMORY_BRAM_ARBITER -- requirements
Module: memory_bram_arbiter

---
 rtl/memory_bram_arbiter.sv | 159 +++++++++++++++
 tb/tb_memory_bram_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_bram_arbiter.sv
// Two-requester round-robin arbiter in front of a single BRAM port.
// Each transfer runs IDLE -> BUSY -> RELEASE and aborts with 16'hFFFF after TIMEOUT BUSY cycles.
module memory_bram_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        rq0_request,
    input  logic        rq0_write,
    input  logic [31:0] rq0_address,
    input  logic [15:0] rq0_wdata,
    output logic        rq0_ack,
    output logic [15:0] rq0_rdata,

    input  logic        rq1_request,
    input  logic        rq1_write,
    input  logic [31:0] rq1_address,
    input  logic [15:0] rq1_wdata,
    output logic        rq1_ack,
    output logic [15:0] rq1_rdata,

    output logic        mem_request,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,

    output logic        timeout_error,
    input  logic        error_clear
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT - 1);
    localparam logic [DW-1:0] ABORT_DATA = {DW{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_grant;
    logic            r_last_grant;
    logic [CW-1:0]   r_busy_cnt;
    logic            r_mem_request;
    logic            r_mem_write;
    logic [AW-1:0]   r_mem_address;
    logic [DW-1:0]   r_mem_wdata;
    logic            r_rq0_ack;
    logic            r_rq1_ack;
    logic [DW-1:0]   r_rq0_rdata;
    logic [DW-1:0]   r_rq1_rdata;
    logic            r_timeout_error;

    logic            w_any_req;
    logic            w_pick1;
    logic            w_cnt_last;
    logic            w_done;
    logic            w_win_write;
    logic [AW-1:0]   w_win_address;
    logic [DW-1:0]   w_win_wdata;
    logic [DW-1:0]   w_done_data;

    // rq1 wins when it is alone, or on a tie when rq0 was granted last
    assign w_any_req     = rq0_request | rq1_request;
    assign w_pick1       = rq1_request & (~rq0_request | ~r_last_grant);
    assign w_win_write   = w_pick1 ? rq1_write   : rq0_write;
    assign w_win_address = w_pick1 ? rq1_address : rq0_address;
    assign w_win_wdata   = w_pick1 ? rq1_wdata   : rq0_wdata;

    // A real ack in the final BUSY cycle beats the timeout
    assign w_cnt_last  = (r_busy_cnt == CNT_LAST);
    assign w_done      = mem_ack | w_cnt_last;
    assign w_done_data = mem_ack ? mem_rdata : ABORT_DATA;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state         <= S_IDLE;
            r_grant         <= 1'b0;
            r_last_grant    <= 1'b1;
            r_busy_cnt      <= '0;
            r_mem_request   <= 1'b0;
            r_mem_write     <= 1'b0;
            r_mem_address   <= '0;
            r_mem_wdata     <= '0;
            r_rq0_ack       <= 1'b0;
            r_rq1_ack       <= 1'b0;
            r_rq0_rdata     <= '0;
            r_rq1_rdata     <= '0;
            r_timeout_error <= 1'b0;
        end else begin
            r_rq0_ack <= 1'b0;
            r_rq1_ack <= 1'b0;
            // A timeout later in this block overrides a coincident clear
            if (error_clear) begin
                r_timeout_error <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_grant       <= w_pick1;
                        r_last_grant  <= w_pick1;
                        r_mem_write   <= w_win_write;
                        r_mem_address <= w_win_address;
                        r_mem_wdata   <= w_win_wdata;
                        r_mem_request <= 1'b1;
                        r_busy_cnt    <= '0;
                        r_state       <= S_BUSY;
                    end
                end

                S_BUSY: begin
                    if (w_done) begin
                        r_mem_request <= 1'b0;
                        r_state       <= S_RELEASE;
                        if (r_grant) begin
                            r_rq1_ack   <= 1'b1;
                            r_rq1_rdata <= w_done_data;
                        end else begin
                            r_rq0_ack   <= 1'b1;
                            r_rq0_rdata <= w_done_data;
                        end
                        if (!mem_ack) begin
                            r_timeout_error <= 1'b1;
                        end
                    end else begin
                        r_busy_cnt <= r_busy_cnt + CW'(1);
                    end
                end

                S_RELEASE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state       <= S_IDLE;
                    r_mem_request <= 1'b0;
                end
            endcase
        end
    end

    assign mem_request   = r_mem_request;
    assign mem_write     = r_mem_write;
    assign mem_address   = r_mem_address;
    assign mem_wdata     = r_mem_wdata;
    assign rq0_ack       = r_rq0_ack;
    assign rq1_ack       = r_rq1_ack;
    assign rq0_rdata     = r_rq0_rdata;
    assign rq1_rdata     = r_rq1_rdata;
    assign timeout_error = r_timeout_error;

endmodule

// File: tb/tb_memory_bram_arbiter.sv
// Directed bench for memory_bram_arbiter: a table of single transfers plus
// hand sequences for fairness and reset in the middle of a transfer.
module tb_memory_bram_arbiter;

    localparam int unsigned TIMEOUT = 15;

    logic        clk;
    logic        reset_n;
    logic        rq0_request, rq0_write, rq0_ack;
    logic [31:0] rq0_address;
    logic [15:0] rq0_wdata, rq0_rdata;
    logic        rq1_request, rq1_write, rq1_ack;
    logic [31:0] rq1_address;
    logic [15:0] rq1_wdata, rq1_rdata;
    logic        mem_request, mem_write, mem_ack;
    logic [31:0] mem_address;
    logic [15:0] mem_wdata, mem_rdata;
    logic        timeout_error, error_clear;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] prev_rd [2];

    memory_bram_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .rq0_request(rq0_request), .rq0_write(rq0_write), .rq0_address(rq0_address),
        .rq0_wdata(rq0_wdata), .rq0_ack(rq0_ack), .rq0_rdata(rq0_rdata),
        .rq1_request(rq1_request), .rq1_write(rq1_write), .rq1_address(rq1_address),
        .rq1_wdata(rq1_wdata), .rq1_ack(rq1_ack), .rq1_rdata(rq1_rdata),
        .mem_request(mem_request), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .timeout_error(timeout_error), .error_clear(error_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r0, r1, w0, w1;
        logic [31:0] a0, a1;
        logic [15:0] d0, d1;
        int          ack_k;     // BUSY cycle index in which memory acks, -1 = never
        logic [15:0] mrd;
        int          clr_k;     // BUSY cycle index with error_clear pulse, -1 = none
        logic        exp_g;
        int          exp_busy;
        logic        exp_w;
        logic [31:0] exp_a;
        logic [15:0] exp_d;
        logic [15:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs [8];

    function automatic vec_t mk(input logic r0, r1, w0, w1, input logic [31:0] a0, a1,
                                input logic [15:0] d0, d1, input int ack_k, input logic [15:0] mrd,
                                input int clr_k, input logic eg, input int eb, input logic ew,
                                input logic [31:0] ea, input logic [15:0] ed, erd, input logic ee);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1; v.a0 = a0; v.a1 = a1;
        v.d0 = d0; v.d1 = d1; v.ack_k = ack_k; v.mrd = mrd; v.clr_k = clr_k;
        v.exp_g = eg; v.exp_busy = eb; v.exp_w = ew; v.exp_a = ea; v.exp_d = ed;
        v.exp_rd = erd; v.exp_err = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int   busy;
        logic got;
        logic bad;
        @(negedge clk);
        rq0_request = v.r0; rq0_write = v.w0; rq0_address = v.a0; rq0_wdata = v.d0;
        rq1_request = v.r1; rq1_write = v.w1; rq1_address = v.a1; rq1_wdata = v.d1;
        @(negedge clk);
        busy = 0; got = 1'b0; bad = 1'b0;
        while (!got && busy < 40) begin
            if (mem_request !== 1'b1 || mem_write !== v.exp_w ||
                mem_address !== v.exp_a || mem_wdata !== v.exp_d) bad = 1'b1;
            mem_ack     = (busy == v.ack_k);
            mem_rdata   = (busy == v.ack_k) ? v.mrd : (16'h0F0F ^ 16'(busy));
            error_clear = (busy == v.clr_k);
            if (busy == 1) begin
                rq0_address = ~rq0_address; rq1_address = ~rq1_address;
                rq0_wdata   = ~rq0_wdata;   rq1_wdata   = ~rq1_wdata;
                rq0_write   = ~rq0_write;   rq1_write   = ~rq1_write;
            end
            @(negedge clk);
            busy++;
            got = rq0_ack | rq1_ack;
        end
        mem_ack = 1'b0; error_clear = 1'b0;
        rq0_request = 1'b0; rq1_request = 1'b0;
        chk("ack_seen", 32'(got), 32'd1);
        chk("busy_cycles", 32'(busy), 32'(v.exp_busy));
        chk("mem_stable_in_busy", 32'(bad), 32'd0);
        chk("rq0_ack", 32'(rq0_ack), 32'(!v.exp_g));
        chk("rq1_ack", 32'(rq1_ack), 32'(v.exp_g));
        chk("rdata_granted", 32'(v.exp_g ? rq1_rdata : rq0_rdata), 32'(v.exp_rd));
        chk("rdata_other_held", 32'(v.exp_g ? rq0_rdata : rq1_rdata), 32'(prev_rd[!v.exp_g]));
        chk("release_mem_request", 32'(mem_request), 32'd0);
        chk("timeout_error", 32'(timeout_error), 32'(v.exp_err));
        prev_rd[v.exp_g] = v.exp_rd;
        // Stray mem_ack while idle must be ignored
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        @(negedge clk);
        chk("idle_ack_pulse_done", 32'({rq1_ack, rq0_ack}), 32'd0);
        chk("idle_stray_rdata", 32'({rq1_rdata, rq0_rdata}), 32'({prev_rd[1], prev_rd[0]}));
        chk("idle_mem_request", 32'(mem_request), 32'd0);
        mem_ack = 1'b0;
    endtask

    initial begin
        int   n;
        int   low_cnt;
        logic prev_req;
        logic seen;

        reset_n = 1'b0; error_clear = 1'b0;
        rq0_request = 1'b0; rq0_write = 1'b0; rq0_address = '0; rq0_wdata = '0;
        rq1_request = 1'b0; rq1_write = 1'b0; rq1_address = '0; rq1_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        prev_rd[0] = '0; prev_rd[1] = '0;

        vecs[0] = mk(1,0,0,0, 32'h0000_2004, 32'h0, 16'h0, 16'h0, 2, 16'hA5C3, -1,
                     0, 3, 0, 32'h0000_2004, 16'h0000, 16'hA5C3, 0);
        vecs[1] = mk(0,1,0,1, 32'h0, 32'h0000_6002, 16'h0, 16'h1234, 1, 16'h0BAD, -1,
                     1, 2, 1, 32'h0000_6002, 16'h1234, 16'h0BAD, 0);
        vecs[2] = mk(1,1,0,1, 32'h100, 32'h200, 16'hAAAA, 16'h5555, 0, 16'h1111, -1,
                     0, 1, 0, 32'h100, 16'hAAAA, 16'h1111, 0);
        vecs[3] = mk(1,1,0,1, 32'h100, 32'h200, 16'hAAAA, 16'h5555, 3, 16'h2222, -1,
                     1, 4, 1, 32'h200, 16'h5555, 16'h2222, 0);
        vecs[4] = mk(1,0,1,0, 32'h8000, 32'h0, 16'hBEEF, 16'h0, -1, 16'h3333, -1,
                     0, 15, 1, 32'h8000, 16'hBEEF, 16'hFFFF, 1);
        vecs[5] = mk(0,1,0,0, 32'h0, 32'hFFFF_FFFE, 16'h0, 16'h0, 14, 16'h5A5A, 0,
                     1, 15, 0, 32'hFFFF_FFFE, 16'h0, 16'h5A5A, 0);
        vecs[6] = mk(1,0,0,0, 32'h10, 32'h0, 16'h0, 16'h0, -1, 16'h4444, 14,
                     0, 15, 0, 32'h10, 16'h0, 16'hFFFF, 1);
        vecs[7] = mk(1,1,1,0, 32'h30, 32'h20, 16'h9999, 16'hC0DE, 0, 16'h7777, -1,
                     1, 1, 0, 32'h20, 16'hC0DE, 16'h7777, 1);

        repeat (2) @(negedge clk);
        chk("rst_mem_request", 32'(mem_request), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_acks", 32'({rq1_ack, rq0_ack}), 32'd0);
        chk("rst_rdata", 32'({rq1_rdata, rq0_rdata}), 32'd0);
        chk("rst_timeout_error", 32'(timeout_error), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Both request continuously: grants alternate starting with rq0
        @(negedge clk);
        rq0_request = 1'b1; rq1_request = 1'b1;
        n = 0; low_cnt = 0; prev_req = 1'b0;
        for (int cyc = 0; cyc < 300 && n < 8; cyc++) begin
            @(negedge clk);
            if (rq0_ack | rq1_ack) begin
                chk("fair_grant", 32'({rq1_ack, rq0_ack}), (n % 2 == 1) ? 32'd2 : 32'd1);
                n++;
            end
            if (mem_request) begin
                if (!prev_req && n > 0) chk("fair_gap_ge1", 32'(low_cnt >= 1), 32'd1);
                low_cnt = 0;
            end else begin
                low_cnt++;
            end
            prev_req  = mem_request;
            mem_ack   = mem_request;
            mem_rdata = 16'(n);
        end
        chk("fair_transfers", 32'(n), 32'd8);
        rq0_request = 1'b0; rq1_request = 1'b0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);

        // Reset during BUSY of an rq0 transfer (which would hand the next tie to rq1)
        rq0_request = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy_entered", 32'(mem_request), 32'd1);
        @(negedge clk);
        reset_n = 1'b0; rq0_request = 1'b0;
        @(negedge clk);
        chk("rst_mid_mem_request", 32'(mem_request), 32'd0);
        chk("rst_mid_acks", 32'({rq1_ack, rq0_ack}), 32'd0);
        chk("rst_mid_timeout_error", 32'(timeout_error), 32'd0);
        chk("rst_mid_rdata", 32'({rq1_rdata, rq0_rdata}), 32'd0);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | rq0_ack | rq1_ack;
        end
        chk("rst_mid_no_ack", 32'(seen), 32'd0);

        rq0_request = 1'b1; rq1_request = 1'b1;
        seen = 1'b0;
        for (int cyc = 0; cyc < 50 && !seen; cyc++) begin
            @(negedge clk);
            if (rq0_ack | rq1_ack) begin
                seen = 1'b1;
                chk("rst_tie_winner", 32'({rq1_ack, rq0_ack}), 32'd1);
            end
            mem_ack   = mem_request;
            mem_rdata = 16'h00C5;
        end
        chk("rst_tie_served", 32'(seen), 32'd1);
        rq0_request = 1'b0; rq1_request = 1'b0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
